sram_port_arbiter: RTL

//  Shares one single-port synchronous SRAM (sram_wrapper: cs_n/we_n/be_n/addr/wdata/rdata, 1-cycle read latency)

---
 rtl/sram_port_arbiter_pkg.sv | 11 +
 rtl/sram_port_arbiter_if.sv | 40 ++++
 rtl/sram_port_arbiter_starve_ctr.sv | 37 +++
 rtl/sram_port_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared owner encoding and starvation-counter width for the SRAM port arbiter.
package sram_port_arbiter_pkg;

  typedef enum logic {
    OwnerA = 1'b0,
    OwnerB = 1'b1
  } owner_e;

  localparam int unsigned StarveW = 8;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// One valid/ready requester port (request + read response) of the SRAM port arbiter.
interface sram_port_arbiter_if #(
  parameter int unsigned W_DATA = 32,
  parameter int unsigned W_ADDR = 11
);

  localparam int unsigned W_BYTES = W_DATA / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [W_ADDR-1:0] req_addr;
  logic [W_BYTES-1:0] req_wmask;
  logic [W_DATA-1:0] req_wdata;
  logic              rsp_valid;
  logic [W_DATA-1:0] rsp_rdata;

  modport master (
    output req_valid,
    input  req_ready,
    output req_write,
    output req_addr,
    output req_wmask,
    output req_wdata,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_write,
    input  req_addr,
    input  req_wmask,
    input  req_wdata,
    output rsp_valid,
    output rsp_rdata
  );

endinterface

// File: rtl/sram_port_arbiter_starve_ctr.sv
// Counts consecutive cycles port B is left waiting; force_b_o lets B win once the limit is hit.
module sram_port_arbiter_starve_ctr
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic b_valid_i,
  input  logic b_accept_i,
  output logic force_b_o
);

  localparam logic [StarveW-1:0] Limit = StarveW'(STARVE_LIMIT);

  logic [StarveW-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (!b_valid_i || b_accept_i) begin
      ctr_d = '0;
    end else if (ctr_q != Limit) begin
      ctr_d = ctr_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign force_b_o = (ctr_q == Limit);

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port (A high priority, B low) arbiter in front of a 1-cycle-latency single-port SRAM.
// Optional anti-starvation for port B is enabled with the SRAM_ARB_ANTI_STARVE_EN macro.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned W_DATA       = 32,
  parameter int unsigned DEPTH        = 2048,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned W_ADDR      = $clog2(DEPTH),
  localparam int unsigned W_BYTES     = W_DATA / 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sram_port_arbiter_if.slave  a_if,
  sram_port_arbiter_if.slave  b_if,
  output logic                sram_cs_n_o,
  output logic                sram_we_n_o,
  output logic [W_BYTES-1:0]  sram_be_n_o,
  output logic [W_ADDR-1:0]   sram_addr_o,
  output logic [W_DATA-1:0]   sram_wdata_o,
  input  logic [W_DATA-1:0]   sram_rdata_i
);

  logic               force_b;
  logic               a_rdy, b_rdy;
  logic               sel_b;
  logic               acc;
  logic               issue;
  logic               mux_write;
  logic [W_ADDR-1:0]  mux_addr;
  logic [W_BYTES-1:0] mux_wmask;
  logic [W_DATA-1:0]  mux_wdata;

  logic   rsp_pending_q, rsp_pending_d;
  owner_e rsp_owner_q, rsp_owner_d;

`ifdef SRAM_ARB_ANTI_STARVE_EN
  sram_port_arbiter_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .b_valid_i  (b_if.req_valid),
    .b_accept_i (b_rdy),
    .force_b_o  (force_b)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_b = 1'b0;
`endif

  // Ready already implies valid, so ready doubles as the accept strobe.
  always_comb begin
    a_rdy = !rst_i && a_if.req_valid && !(force_b && b_if.req_valid);
    b_rdy = !rst_i && b_if.req_valid && (!a_if.req_valid || force_b);
  end

  assign a_if.req_ready = a_rdy;
  assign b_if.req_ready = b_rdy;

  always_comb begin
    sel_b     = b_rdy;
    acc       = a_rdy || b_rdy;
    mux_write = sel_b ? b_if.req_write : a_if.req_write;
    mux_addr  = sel_b ? b_if.req_addr  : a_if.req_addr;
    mux_wmask = sel_b ? b_if.req_wmask : a_if.req_wmask;
    mux_wdata = sel_b ? b_if.req_wdata : a_if.req_wdata;
    // An all-zero write mask is accepted but never touches the SRAM.
    issue     = acc && (!mux_write || (|mux_wmask));
  end

  always_comb begin
    sram_cs_n_o  = !issue;
    sram_we_n_o  = !(issue && mux_write);
    sram_be_n_o  = (issue && mux_write) ? ~mux_wmask : '1;
    sram_addr_o  = mux_addr;
    sram_wdata_o = mux_wdata;
  end

  always_comb begin
    rsp_pending_d = issue && !mux_write;
    rsp_owner_d   = sel_b ? OwnerB : OwnerA;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= OwnerA;
    end else begin
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
    end
  end

  // Gating with rst_i drops a read that was in flight when reset arrived.
  always_comb begin
    a_if.rsp_valid = !rst_i && rsp_pending_q && (rsp_owner_q == OwnerA);
    b_if.rsp_valid = !rst_i && rsp_pending_q && (rsp_owner_q == OwnerB);
    a_if.rsp_rdata = sram_rdata_i;
    b_if.rsp_rdata = sram_rdata_i;
  end

endmodule
